// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the icache and dcache line engines.
// Each grant runs a full-line burst of WORDS_PER_LINE word beats. The FSM runs
// IDLE -> BURST -> TURN -> IDLE.
// Define ARB_ROUND_ROBIN_EN to alternate grants on a tie; otherwise the dcache always wins ties.
module mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_valid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wnext,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_valid,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned       CNT_W     = $clog2(WORDS_PER_LINE);
    localparam int unsigned       OFF_W     = CNT_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, BURST, TURN} state_t;

    state_t              r_state;
    logic                r_grant_dc;   // 1: dcache owns the current burst
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
`ifdef ARB_ROUND_ROBIN_EN
    logic                r_last_dc;    // 1: dcache was granted most recently
`endif

    logic                w_pick_dc;
    logic [ADDR_W-1:0]   w_req_base;
    logic [CNT_W-1:0]    w_next_cnt;
    logic                w_beat;
    logic                w_last;

    // Pick the winner among the current requesters; a single requester always wins.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (ic_req && dc_req) begin
            w_pick_dc = ~r_last_dc;
        end else begin
            w_pick_dc = dc_req;
        end
`else
        w_pick_dc = dc_req;
`endif
        w_req_base = (w_pick_dc ? dc_addr : ic_addr) & LINE_MASK;
    end

    assign w_next_cnt = r_cnt + CNT_W'(1);
    assign w_beat     = (r_state == BURST) && mem_ack;
    assign w_last     = (r_cnt == LAST_CNT);

    // Burst sequencing: grant, beat counting, registered memory-port controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant_dc <= 1'b0;
            r_base     <= '0;
            r_cnt      <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_dc  <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        r_grant_dc <= w_pick_dc;
                        r_base     <= w_req_base;
                        r_cnt      <= '0;
                        r_mem_addr <= w_req_base;
                        r_mem_we   <= w_pick_dc & dc_we;
                        r_mem_req  <= 1'b1;
                        r_state    <= BURST;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_dc  <= w_pick_dc;
`endif
                    end
                end
                BURST: begin
                    if (mem_ack) begin
                        r_cnt      <= w_next_cnt;
                        r_mem_addr <= r_base | (ADDR_W'(w_next_cnt) << 2);
                        if (w_last) begin
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            r_state   <= TURN;
                        end
                    end
                end
                // One dead cycle so the finished requester can drop its request.
                TURN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Beat strobes are combinational from mem_ack so data is never delayed.
    always_comb begin
        ic_valid = w_beat & ~r_grant_dc;
        dc_valid = w_beat & r_grant_dc & ~r_mem_we;
        dc_wnext = w_beat & r_grant_dc & r_mem_we;
        ic_done  = w_beat & w_last & ~r_grant_dc;
        dc_done  = w_beat & w_last & r_grant_dc;
    end

    assign ic_rdata  = mem_rdata;
    assign dc_rdata  = mem_rdata;
    assign mem_wdata = dc_wdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;

endmodule
